// File: rtl/irom_if.sv
// irom_if: byte-stream load port and instruction fetch port of the instruction store
interface irom_if #(
  parameter int ADDR_W = 14
);
  logic [ADDR_W-1:0] pc;
  logic [31:0]       instr;
  logic              ld_valid;
  logic [7:0]        ld_data;
  logic              ld_last;
  logic              ld_ready;
  modport master (output pc, ld_valid, ld_data, ld_last, input instr, ld_ready);
  modport slave  (input pc, ld_valid, ld_data, ld_last, output instr, ld_ready);
endinterface

// File: rtl/irom_loader.sv
// irom_loader: loads a little-endian byte image into instruction memory, holding the CPU in reset until done
module irom_loader #(
  parameter int          ADDR_W   = 14,
  parameter logic [31:0] NOP_WORD = 32'h0000_0013
) (
  input  logic              clk,
  input  logic              rst_n,
  irom_if.slave             bus,
  input  logic              reload,
  output logic              cpu_rst_n,
  output logic [ADDR_W:0]   word_cnt,
  output logic              err_ovf
);
  typedef enum logic {LOAD, RUN} state_t;
  state_t      state;
  logic [1:0]  byte_idx;
  logic [23:0] asm_reg;
  logic [31:0] mem [2**ADDR_W];
  logic        xfer, do_write, full;
  logic [31:0] nxt_word;
  assign bus.ld_ready = state == LOAD;
  assign xfer         = rst_n & bus.ld_valid & bus.ld_ready;
  assign do_write     = xfer & (byte_idx == 2'd3 | bus.ld_last);
  assign full         = word_cnt[ADDR_W];
  // upper bytes of asm_reg stay zero, giving zero padding for short final words
  assign nxt_word     = {8'b0, asm_reg} | (32'(bus.ld_data) << {byte_idx, 3'b000});
  assign bus.instr    = state == RUN ? mem[bus.pc] : NOP_WORD;
  always_ff @(posedge clk)
    if (do_write && !full) mem[word_cnt[ADDR_W-1:0]] <= nxt_word;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= LOAD;
      cpu_rst_n <= 1'b0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      asm_reg   <= '0;
      err_ovf   <= 1'b0;
    end else if (state == RUN) begin
      if (reload) begin
        state     <= LOAD;
        cpu_rst_n <= 1'b0;
        word_cnt  <= '0;
        byte_idx  <= '0;
        asm_reg   <= '0;
        err_ovf   <= 1'b0;
      end
    end else if (xfer) begin
      byte_idx <= do_write ? 2'd0 : byte_idx + 2'd1;
      asm_reg  <= do_write ? 24'd0 : nxt_word[23:0];
      if (do_write && full) err_ovf <= 1'b1;
      if (do_write && !full) word_cnt <= word_cnt + {{ADDR_W{1'b0}}, 1'b1};
      if (bus.ld_last) begin
        state     <= RUN;
        cpu_rst_n <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_irom_loader.sv
// tb_irom_loader: scoreboard bench loading images into a full-size and a 4-word loader
module tb_irom_loader;
  logic        clk = 1'b0;
  logic        rst_n, reload_a, reload_b;
  logic        cpu_rst_n_a, cpu_rst_n_b, err_a, err_b;
  logic [14:0] word_cnt_a;
  logic [2:0]  word_cnt_b;
  logic [7:0]  img [$];
  logic [31:0] exp_q [$];
  int          checks = 0;
  int          failures = 0;

  always #5 clk = ~clk;

  irom_if #(.ADDR_W(14)) bus_a ();
  irom_if #(.ADDR_W(2))  bus_b ();

  irom_loader #(.ADDR_W(14)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a.slave), .reload(reload_a),
    .cpu_rst_n(cpu_rst_n_a), .word_cnt(word_cnt_a), .err_ovf(err_a)
  );
  irom_loader #(.ADDR_W(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b.slave), .reload(reload_b),
    .cpu_rst_n(cpu_rst_n_b), .word_cnt(word_cnt_b), .err_ovf(err_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic set_pc(input bit sel, input int p);
    if (sel) bus_b.pc = 2'(p);
    else bus_a.pc = 14'(p);
  endtask

  function automatic logic [31:0] instr_of(input bit sel);
    return sel ? bus_b.instr : bus_a.instr;
  endfunction

  task automatic send(input bit sel, input logic [7:0] d, input bit last, input bit rnd);
    for (int k = 0; k < 8 && rnd && $urandom_range(1, 0) == 1; k++) begin
      set_pc(sel, int'($urandom_range(16383, 0)));
      #1 check("load_nop", instr_of(sel), 32'h0000_0013);
      @(negedge clk);
    end
    if (sel) begin
      bus_b.ld_data = d; bus_b.ld_last = last; bus_b.ld_valid = 1'b1;
    end else begin
      bus_a.ld_data = d; bus_a.ld_last = last; bus_a.ld_valid = 1'b1;
    end
    @(negedge clk);
    bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0;
    bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0;
  endtask

  // expected words come from the byte image alone; words past the store depth are dropped
  task automatic load(input bit sel, input bit rnd, input int depth);
    for (int i = 0; i < img.size(); i += 4) begin
      logic [31:0] w = '0;
      for (int k = 0; k < 4; k++)
        if (i + k < img.size()) w[8*k +: 8] = img[i+k];
      if (i / 4 < depth) exp_q.push_back(w);
    end
    for (int i = 0; i < img.size(); i++) send(sel, img[i], i == img.size() - 1, rnd);
  endtask

  task automatic drain(input bit sel);
    int n = 0;
    while (exp_q.size() > 0) begin
      logic [31:0] w = exp_q.pop_front();
      set_pc(sel, n);
      #1 check($sformatf("mem%0d_%0d", sel, n), instr_of(sel), w);
      @(negedge clk);
      n++;
    end
  endtask

  task automatic pulse_reload(input bit sel);
    if (sel) reload_b = 1'b1;
    else reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0; reload_b = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; reload_a = 1'b0; reload_b = 1'b0;
    bus_a.ld_valid = 1'b0; bus_a.ld_last = 1'b0; bus_a.ld_data = '0; bus_a.pc = 14'd5;
    bus_b.ld_valid = 1'b0; bus_b.ld_last = 1'b0; bus_b.ld_data = '0; bus_b.pc = 2'd1;
    repeat (2) @(negedge clk);
    check("rst_ready", bus_a.ld_ready, 1);
    check("rst_cpu", cpu_rst_n_a, 0);
    check("rst_cnt", word_cnt_a, 0);
    check("rst_err", err_a, 0);
    check("rst_instr", bus_a.instr, 32'h0000_0013);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_ready", bus_a.ld_ready, 1);

    img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    load(0, 0, 1 << 14);
    check("img1_cpu", cpu_rst_n_a, 1);
    check("img1_ready", bus_a.ld_ready, 0);
    check("img1_cnt", word_cnt_a, 2);
    drain(0);
    bus_a.pc = 14'd1;
    #1 check("img1_pc1", bus_a.instr, 32'h0020_0593);
    @(negedge clk);

    pulse_reload(0);
    check("rl_cpu", cpu_rst_n_a, 0);
    check("rl_ready", bus_a.ld_ready, 1);
    check("rl_cnt", word_cnt_a, 0);
    check("rl_err", err_a, 0);
    img = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h11, 8'h22};
    load(0, 0, 1 << 14);
    check("img2_cnt", word_cnt_a, 2);
    drain(0);
    bus_a.pc = 14'd1;
    #1 check("img2_pad", bus_a.instr, 32'h0000_2211);
    @(negedge clk);

    pulse_reload(0);
    img = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'h20, 8'h00};
    load(0, 1, 1 << 14);
    check("img3_cnt", word_cnt_a, 2);
    drain(0);

    pulse_reload(0);
    img = '{8'h6F, 8'h00, 8'h00, 8'h00};
    load(0, 0, 1 << 14);
    check("img4_cnt", word_cnt_a, 1);
    check("img4_cpu", cpu_rst_n_a, 1);
    drain(0);
    bus_a.pc = 14'd1;
    #1 check("img4_retain", bus_a.instr, 32'h0020_0593);
    @(negedge clk);

    pulse_reload(0);
    send(0, 8'hAB, 0, 0);
    send(0, 8'hCD, 0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("mid_rst_ready", bus_a.ld_ready, 1);
    check("mid_rst_cnt", word_cnt_a, 0);
    check("mid_rst_cpu", cpu_rst_n_a, 0);
    img = '{8'h01, 8'h02, 8'h03, 8'h04};
    load(0, 0, 1 << 14);
    drain(0);
    bus_a.pc = 14'd0;
    #1 check("img5_clean", bus_a.instr, 32'h0403_0201);
    @(negedge clk);

    img = {};
    for (int i = 0; i < 20; i++) img.push_back(8'(i + 1));
    for (int i = 0; i < 16; i++) send(1, img[i], 0, 0);
    check("ovf_pre_err", err_b, 0);
    check("ovf_pre_cnt", word_cnt_b, 4);
    img = img[16:19];
    for (int i = 0; i < 4; i++) send(1, img[i], i == 3, 0);
    check("ovf_err", err_b, 1);
    check("ovf_cnt", word_cnt_b, 4);
    check("ovf_cpu", cpu_rst_n_b, 1);
    for (int i = 0; i < 4; i++)
      exp_q.push_back({8'(4*i + 4), 8'(4*i + 3), 8'(4*i + 2), 8'(4*i + 1)});
    drain(1);
    pulse_reload(1);
    check("ovf_rl_err", err_b, 0);
    check("ovf_rl_cnt", word_cnt_b, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
